// File: rtl/atan2_cordic_if.sv
// Vector-in / angle-out bundle for the atan2 CORDIC pipeline.
// No handshake: a new vector may be presented every cycle.
interface atan2_cordic_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] sink_x;
  logic signed [WIDTH-1:0] sink_y;
  logic signed [WIDTH-1:0] source;

  modport master (output sink_x, output sink_y, input source);
  modport slave  (input sink_x, input sink_y, output source);
endinterface

// File: rtl/atan2_cordic.sv
// Fully pipelined four-quadrant arctangent, CORDIC vectoring mode.
// Stage 1 folds the vector into the right half-plane, stages 2 and 3 each run
// half of the micro-rotations, stage 4 rounds and saturates the angle.
// The result is available exactly 4 cycles after the vector is sampled.
module atan2_cordic #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  atan2_cordic_if.slave  bus
);

  localparam int XW    = WIDTH + 4;   // 2 integer guard bits + 2 fractional guard bits
  localparam int ZW    = WIDTH + 2;   // internal angle: 1 LSB = 2^-(WIDTH-1) rad
  localparam int NITER = WIDTH - 2;
  localparam int N1    = NITER / 2;
  localparam int N2    = NITER - N1;

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    for (int k = 0; k < n; k++) r = r * 2.0;
    return r;
  endfunction

  function automatic int scaled_pi(input int frac_bits);
    return $rtoi(3.141592653589793 * pow2(frac_bits) + 0.5);
  endfunction

  // round(atan(2^-i) * 2^(WIDTH-1)); the Taylor series converges fast for t <= 1/2.
  function automatic logic signed [ZW-1:0] atan_const(input int i);
    real t, term, sum;
    int  v;
    t = 1.0;
    for (int k = 0; k < i; k++) t = t / 2.0;
    if (i == 0) begin
      sum = 0.7853981633974483;
    end else begin
      sum  = 0.0;
      term = t;
      for (int k = 0; k < 40; k++) begin
        if (k % 2 == 1) sum = sum - term / real'(2 * k + 1);
        else            sum = sum + term / real'(2 * k + 1);
        term = term * t * t;
      end
    end
    v = $rtoi(sum * pow2(WIDTH - 1) + 0.5);
    return v[ZW-1:0];
  endfunction

  localparam int                     PI_Z_I = scaled_pi(WIDTH - 1);
  localparam int                     PI_O_I = scaled_pi(WIDTH - 3);
  localparam logic signed [ZW-1:0]    PI_Z   = PI_Z_I[ZW-1:0];
  localparam logic signed [WIDTH-1:0] PI_O   = PI_O_I[WIDTH-1:0];
  localparam logic signed [ZW-1:0]    HALF   = 2;

  // rot = 0 means the angle is known exactly without rotating (y == 0);
  // the output is then 0 or +pi depending on pi.
  typedef struct packed {
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] y;
    logic signed [ZW-1:0] z;
    logic                 rot;
    logic                 pi;
  } stage_t;

  function automatic stage_t rotate(input stage_t s, input int sh,
                                    input logic signed [ZW-1:0] k);
    stage_t r;
    logic signed [XW-1:0] xs, ys, xsh, ysh;
    r   = s;
    xs  = s.x;
    ys  = s.y;
    xsh = xs >>> sh;
    ysh = ys >>> sh;
    if (!ys[XW-1]) begin
      r.x = xs + ysh;
      r.y = ys - xsh;
      r.z = s.z + k;
    end else begin
      r.x = xs - ysh;
      r.y = ys + xsh;
      r.z = s.z - k;
    end
    return r;
  endfunction

  logic signed [XW-1:0]    xe, ye;
  logic                    x_neg;
  stage_t                  s1_d, s1_q, s2_q;
  stage_t                  chain_a [0:N1];
  stage_t                  chain_b [0:N2];
  logic signed [ZW-1:0]    z3_q;
  logic                    rot3_q, pi3_q;
  logic signed [WIDTH-1:0] zq, zsat, source_d, source_q;

  // Quadrant fold: mirror left-half-plane vectors and start z at +/-pi.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    s1_d  = '0;
    xe    = {{2{bus.sink_x[WIDTH-1]}}, bus.sink_x, 2'b00};
    ye    = {{2{bus.sink_y[WIDTH-1]}}, bus.sink_y, 2'b00};
    x_neg = bus.sink_x[WIDTH-1];
    s1_d.x   = x_neg ? -xe : xe;
    s1_d.y   = x_neg ? -ye : ye;
    s1_d.z   = !x_neg ? '0 : (bus.sink_y[WIDTH-1] ? -PI_Z : PI_Z);
    s1_d.rot = |bus.sink_y;
    s1_d.pi  = x_neg;
  end

  assign chain_a[0] = s1_q;
  for (genvar i = 0; i < N1; i++) begin : g_rot_a
    localparam logic signed [ZW-1:0] K = atan_const(i);
    assign chain_a[i+1] = rotate(chain_a[i], i, K);
  end

  assign chain_b[0] = s2_q;
  for (genvar i = 0; i < N2; i++) begin : g_rot_b
    localparam logic signed [ZW-1:0] K = atan_const(N1 + i);
    assign chain_b[i+1] = rotate(chain_b[i], N1 + i, K);
  end

  // Output stage: round half-up to WIDTH bits, clamp to +/-pi, or emit the exact case.
  always_comb begin
    zq = WIDTH'((z3_q + HALF) >>> 2);
    if (zq > PI_O)       zsat = PI_O;
    else if (zq < -PI_O) zsat = -PI_O;
    else                 zsat = zq;
    source_d = rot3_q ? zsat : (pi3_q ? PI_O : '0);
  end

  // Pipeline registers; reset clears every stage so only zero-vector results drain out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      z3_q     <= '0;
      rot3_q   <= 1'b0;
      pi3_q    <= 1'b0;
      source_q <= '0;
    end else begin
      // NOTE: non-blocking so each stage captures its predecessor's pre-edge value.
      s1_q     <= s1_d;
      s2_q     <= chain_a[N1];
      z3_q     <= chain_b[N2].z;
      rot3_q   <= chain_b[N2].rot;
      pi3_q    <= chain_b[N2].pi;
      source_q <= source_d;
    end
  end

  assign bus.source = source_q;

endmodule

// File: tb/tb_atan2_cordic.sv
// Directed bench for atan2_cordic: cardinal/diagonal/extreme vectors with
// hand-computed angles, a full rotating sweep, and asynchronous reset mid-stream.
module tb_atan2_cordic;

  localparam int  WIDTH = 16;
  localparam real PI_R  = 3.141592653589793;
  localparam real TOL_R = 3.0 / 8192.0 + 1.0e-9;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  atan2_cordic_if #(.WIDTH(WIDTH)) bus ();

  atan2_cordic #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic real phase_of(input int cnt);
    shortint s;
    s = shortint'(cnt);
    return real'(s) / 10430.37835;
  endfunction

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    n_total++;
    assert (diff <= tol) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
  endtask

  task automatic check_phase(input string tag, input int cnt);
    real ph, err;
    ph  = phase_of(cnt);
    err = real'(int'(bus.source)) / 8192.0 - ph;
    if (err > PI_R)       err = err - 2.0 * PI_R;
    else if (err < -PI_R) err = err + 2.0 * PI_R;
    n_total++;
    assert ((err <= TOL_R) && (err >= -TOL_R)) n_pass++;
    else $error("FAIL %s: cnt %0d observed %0d expected %f rad (err %f rad)",
                tag, cnt, int'(bus.source), ph, err);
  endtask

  task automatic drive_phase(input int cnt);
    real ph;
    ph = phase_of(cnt);
    bus.sink_x = WIDTH'(rnd(16384.0 * $cos(ph)));
    bus.sink_y = WIDTH'(rnd(16384.0 * $sin(ph)));
  endtask

  // One vector for one cycle between zeros; result must show after the 4th edge only.
  task automatic run_vec(input string tag, input int x, input int y,
                         input int exp, input int tol, input bit chk_early);
    @(negedge clk);
    bus.sink_x = WIDTH'(x);
    bus.sink_y = WIDTH'(y);
    @(negedge clk);
    bus.sink_x = '0;
    bus.sink_y = '0;
    @(negedge clk);
    @(negedge clk);
    if (chk_early) check({tag, "_early"}, int'(bus.source), 0, 0);
    @(negedge clk);
    check(tag, int'(bus.source), exp, tol);
  endtask

  initial begin
    reset      = 1'b1;
    bus.sink_x = '0;
    bus.sink_y = '0;
    #12;
    check("reset_state", int'(bus.source), 0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("zero_after_reset", int'(bus.source), 0, 0);

    // Cardinal points with exact-latency check
    run_vec("card_0",    16384,      0,      0, 3, 1'b1);
    run_vec("card_90",       0,  16384,  12868, 3, 1'b1);
    run_vec("card_180", -16384,      0,  25736, 3, 1'b1);
    run_vec("card_270",      0, -16384, -12868, 3, 1'b1);

    // Diagonals
    run_vec("diag_45",    11585,  11585,   6434, 3, 1'b0);
    run_vec("diag_m135", -11585, -11585, -19302, 3, 1'b0);
    run_vec("diag_m45",   11585, -11585,  -6434, 3, 1'b0);
    run_vec("diag_135",  -11585,  11585,  19302, 3, 1'b0);

    // Amplitude independence and extremes
    run_vec("amp4k_0",     4096,      0,      0, 3, 1'b0);
    run_vec("amp4k_90",       0,   4096,  12868, 3, 1'b0);
    run_vec("amp4k_45",    2896,   2896,   6434, 3, 1'b0);
    run_vec("amp32k_0",   32767,      0,      0, 3, 1'b0);
    run_vec("amp32k_90",      0,  32767,  12868, 3, 1'b0);
    run_vec("amp32k_45",  23170,  23170,   6434, 3, 1'b0);
    run_vec("amp32k_m90",     0, -32768, -12868, 3, 1'b0);
    run_vec("ext_mm",    -32768, -32768, -19302, 3, 1'b0);
    run_vec("ext_pm",     32767, -32768,  -6434, 3, 1'b0);
    run_vec("ext_m0",    -32768,      0,  25736, 0, 1'b0);

    // Degenerate vectors
    run_vec("degen_00",       0,      0,      0, 0, 1'b0);
    run_vec("degen_m5",      -5,      0,  25736, 0, 1'b0);

    // Rotating sweep over a full shortint wrap; source lags the phase by 4 samples
    for (int c = 0; c < 65540; c++) begin
      @(negedge clk);
      if (c >= 4) check_phase("sweep", c - 4);
      drive_phase(c);
    end

    // Asynchronous reset in the middle of a rotating stream
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive_phase(2000 + c);
    end
    check_phase("pre_reset", 2003);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", int'(bus.source), 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", int'(bus.source), 0, 0);
    reset = 1'b0;
    drive_phase(3000);
    #1;
    check("post_rel_0", int'(bus.source), 0, 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rel_%0d", k), int'(bus.source), 0, 0);
      drive_phase(3000 + k);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_phase($sformatf("post_rel_data_%0d", k), 3000 + k);
      drive_phase(3004 + k);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
